// File: rtl/elbeth_fetch_unit_pkg.sv
// elbeth_fetch_unit_pkg: fetch-stage state encodings, PC select codes and constants
package elbeth_fetch_unit_pkg;
  typedef enum logic [1:0] {RST_WAIT, FETCH, HOLD, DROP} fetch_state_t;
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_XCPT = 2'd2;
  localparam logic [1:0] PC_SEL_EPC = 2'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
endpackage

// File: rtl/elbeth_fetch_unit_if.sv
// elbeth_fetch_unit_if: instruction-memory request/response bus
interface elbeth_fetch_unit_if;
  logic [31:0] imem_addr;
  logic imem_en;
  logic imem_ready;
  logic [31:0] imem_rdata;
  modport master(output imem_addr, imem_en, input imem_ready, imem_rdata);
  modport slave(input imem_addr, imem_en, output imem_ready, imem_rdata);
endinterface

// File: rtl/elbeth_pc_mux.sv
// elbeth_pc_mux: 4:1 next-PC target select
module elbeth_pc_mux
  import elbeth_fetch_unit_pkg::*;
(
  input  logic [1:0]  if_pc_select,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] id_branch_target,
  input  logic [31:0] exs_xcpt_handler,
  input  logic [31:0] exs_epc,
  output logic [31:0] target
);
  always_comb
    target = (if_pc_select == PC_SEL_BRANCH) ? id_branch_target :
             (if_pc_select == PC_SEL_XCPT)   ? exs_xcpt_handler :
             (if_pc_select == PC_SEL_EPC)    ? exs_epc : pc_plus4;
endmodule

// File: rtl/elbeth_fetch_unit.sv
// elbeth_fetch_unit: IF stage owning the PC, imem handshake, hold buffer and pending redirect
module elbeth_fetch_unit
  import elbeth_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 if_pc_select,
  input  logic                       if_pc_stall,
  input  logic                       if_stall,
  input  logic [31:0]                id_branch_target,
  input  logic [31:0]                exs_xcpt_handler,
  input  logic [31:0]                exs_epc,
  elbeth_fetch_unit_if.master        imem,
  output logic                       if_imem_en,
  output logic [31:0]                if_instruction,
  output logic [6:0]                 if_opcode,
  output logic [2:0]                 if_funct3,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_pc_plus4,
  output logic                       if_valid,
  output logic                       if_except,
  output logic [3:0]                 if_except_cause
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, hold, hold_n, redir_pc, redir_n, pc_plus4, target, instr;
  logic redirect, stall, misaligned, en, valid, except;
  assign pc_plus4 = pc + 32'd4;
  elbeth_pc_mux u_pc_mux (
    .if_pc_select     (if_pc_select),
    .pc_plus4         (pc_plus4),
    .id_branch_target (id_branch_target),
    .exs_xcpt_handler (exs_xcpt_handler),
    .exs_epc          (exs_epc),
    .target           (target)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RST_WAIT;
      pc <= RESET_ADDR;
      hold <= NOP_INSTR;
      redir_pc <= 32'd0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      hold <= hold_n;
      redir_pc <= redir_n;
    end
  always_comb begin
    redirect = if_pc_select != PC_SEL_PLUS4;
    stall = if_pc_stall | if_stall;
    misaligned = pc[1:0] != 2'b00;
    state_n = state;
    pc_n = pc;
    hold_n = hold;
    redir_n = redir_pc;
    en = 1'b0;
    valid = 1'b0;
    except = 1'b0;
    instr = NOP_INSTR;
    case (state)
      RST_WAIT: state_n = FETCH;
      FETCH:
        if (misaligned) begin
          valid = 1'b1;
          except = 1'b1;
          pc_n = redirect ? target : pc;
        end else begin
          en = 1'b1;
          valid = imem.imem_ready;
          instr = imem.imem_ready ? imem.imem_rdata : NOP_INSTR;
          if (imem.imem_ready) begin
            if (redirect) pc_n = target;
            else if (stall) begin
              hold_n = imem.imem_rdata;
              state_n = HOLD;
            end else pc_n = pc_plus4;
          end else if (redirect) begin
            redir_n = target;
            state_n = DROP;
          end
        end
      HOLD: begin
        valid = 1'b1;
        instr = hold;
        if (redirect || !stall) begin
          pc_n = redirect ? target : pc_plus4;
          state_n = FETCH;
        end
      end
      DROP: begin
        en = 1'b1;
        if (imem.imem_ready) begin
          pc_n = redirect ? target : redir_pc;
          state_n = FETCH;
        end else redir_n = redirect ? target : redir_pc;
      end
      default: state_n = FETCH;
    endcase
  end
  assign imem.imem_addr = pc;
  assign imem.imem_en = en;
  assign if_imem_en = en;
  assign if_instruction = instr;
  assign if_opcode = instr[6:0];
  assign if_funct3 = instr[14:12];
  assign if_pc = pc;
  assign if_pc_plus4 = pc_plus4;
  assign if_valid = valid;
  assign if_except = except;
  assign if_except_cause = except ? EXC_INSTR_MISALIGNED : 4'd0;
endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// tb_elbeth_fetch_unit: directed and random stimulus against a behavioural fetch model
module tb_elbeth_fetch_unit;
  localparam logic [31:0] NOPW = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] sel = 2'd0;
  logic pstall = 1'b0, stall = 1'b0;
  logic [31:0] br = '0, hnd = '0, epc = '0;
  logic if_imem_en, if_valid, if_except;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;
  logic [6:0] if_opcode;
  logic [2:0] if_funct3;
  logic [3:0] if_except_cause;
  int n_checks = 0, n_errors = 0;
  bit checking = 1'b0;
  logic [31:0] m_pc, m_hold, m_pend;
  bit m_boot, m_held, m_drop;
  elbeth_fetch_unit_if imem();
  elbeth_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc_select     (sel),
    .if_pc_stall      (pstall),
    .if_stall         (stall),
    .id_branch_target (br),
    .exs_xcpt_handler (hnd),
    .exs_epc          (epc),
    .imem             (imem),
    .if_imem_en       (if_imem_en),
    .if_instruction   (if_instruction),
    .if_opcode        (if_opcode),
    .if_funct3        (if_funct3),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .if_valid         (if_valid),
    .if_except        (if_except),
    .if_except_cause  (if_except_cause)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic model_compare();
    logic en, valid, exc;
    logic [31:0] instr;
    en = 1'b0;
    valid = 1'b0;
    exc = 1'b0;
    instr = NOPW;
    if (m_boot) ;
    else if (m_held) begin
      valid = 1'b1;
      instr = m_hold;
    end else if (m_drop) en = 1'b1;
    else if (m_pc[1:0] != 2'b00) begin
      valid = 1'b1;
      exc = 1'b1;
    end else begin
      en = 1'b1;
      valid = imem.imem_ready;
      instr = imem.imem_ready ? imem.imem_rdata : NOPW;
    end
    check("imem_en", {31'd0, imem.imem_en}, {31'd0, en});
    check("if_imem_en", {31'd0, if_imem_en}, {31'd0, en});
    if (en) check("imem_addr", imem.imem_addr, m_pc);
    check("if_valid", {31'd0, if_valid}, {31'd0, valid});
    check("if_except", {31'd0, if_except}, {31'd0, exc});
    check("if_except_cause", {28'd0, if_except_cause}, 32'd0);
    check("if_instruction", if_instruction, instr);
    check("if_opcode", {25'd0, if_opcode}, {25'd0, instr[6:0]});
    check("if_funct3", {29'd0, if_funct3}, {29'd0, instr[14:12]});
    check("if_pc", if_pc, m_pc);
    check("if_pc_plus4", if_pc_plus4, m_pc + 32'd4);
  endtask
  task automatic model_step();
    bit redir, hold_stall;
    logic [31:0] tgt;
    redir = sel != 2'd0;
    hold_stall = pstall | stall;
    tgt = sel == 2'd1 ? br : sel == 2'd2 ? hnd : sel == 2'd3 ? epc : m_pc + 32'd4;
    if (!rst) begin
      m_pc = 32'd0;
      m_hold = NOPW;
      m_pend = 32'd0;
      m_boot = 1'b1;
      m_held = 1'b0;
      m_drop = 1'b0;
    end else if (m_boot) m_boot = 1'b0;
    else if (m_held) begin
      if (redir) m_pc = tgt;
      else if (!hold_stall) m_pc = m_pc + 32'd4;
      m_held = redir || hold_stall ? !redir : 1'b0;
    end else if (m_drop) begin
      if (imem.imem_ready) begin
        m_pc = redir ? tgt : m_pend;
        m_drop = 1'b0;
      end else if (redir) m_pend = tgt;
    end else if (m_pc[1:0] != 2'b00) begin
      if (redir) m_pc = tgt;
    end else if (imem.imem_ready) begin
      if (redir) m_pc = tgt;
      else if (hold_stall) begin
        m_hold = imem.imem_rdata;
        m_held = 1'b1;
      end else m_pc = m_pc + 32'd4;
    end else if (redir) begin
      m_pend = tgt;
      m_drop = 1'b1;
    end
  endtask
  task automatic set_in(input logic [1:0] s, input logic st, input logic rdy, input logic [31:0] rd);
    sel = s;
    stall = st;
    pstall = 1'b0;
    imem.imem_ready = rdy;
    imem.imem_rdata = rd;
    #1;
    if (checking) model_compare();
  endtask
  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = '0;
    @(negedge clk);
    set_in(0, 0, 1, $urandom);
    adv();
    checking = 1'b1;
    set_in(0, 0, 1, $urandom);
    adv();
    rst = 1'b1;
    set_in(0, 0, 1, $urandom);
    check("t1_rst_wait_en", {31'd0, imem.imem_en}, 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, $urandom);
      check("t1_seq_addr", imem.imem_addr, 32'(k * 4));
      adv();
    end
    br = 32'h8;
    set_in(1, 0, 1, $urandom);
    adv();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, $urandom);
      check("t2_wait_addr", imem.imem_addr, 32'h8);
      check("t2_wait_valid", {31'd0, if_valid}, 32'd0);
      adv();
    end
    set_in(0, 0, 1, 32'h1234_5678);
    check("t2_ready_instr", if_instruction, 32'h1234_5678);
    adv();
    br = 32'h4;
    set_in(1, 0, 1, $urandom);
    adv();
    set_in(0, 1, 1, 32'h00A0_0093);
    adv();
    set_in(0, 1, 0, $urandom);
    check("t3_hold_instr", if_instruction, 32'h00A0_0093);
    check("t3_hold_en", {31'd0, imem.imem_en}, 32'd0);
    adv();
    set_in(0, 0, 0, $urandom);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t3_release_addr", imem.imem_addr, 32'h8);
    adv();
    br = 32'h10;
    set_in(1, 0, 1, $urandom);
    adv();
    br = 32'h40;
    set_in(1, 0, 0, $urandom);
    adv();
    hnd = 32'h100;
    set_in(2, 0, 0, $urandom);
    check("t4_drop_addr", imem.imem_addr, 32'h10);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t4_drop_valid", {31'd0, if_valid}, 32'd0);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t4_redirect_addr", imem.imem_addr, 32'h100);
    adv();
    br = 32'h42;
    set_in(1, 0, 1, $urandom);
    adv();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 1, $urandom);
      check("t5_misaligned_exc", {31'd0, if_except}, 32'd1);
      check("t5_misaligned_instr", if_instruction, NOPW);
      adv();
    end
    set_in(2, 0, 0, $urandom);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t5_handler_addr", imem.imem_addr, 32'h100);
    adv();
    epc = 32'hFFFF_FFFC;
    set_in(3, 0, 1, $urandom);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t6_epc_addr", imem.imem_addr, 32'hFFFF_FFFC);
    check("t6_plus4_wrap", if_pc_plus4, 32'h0);
    adv();
    set_in(0, 0, 1, $urandom);
    check("t6_wrap_addr", imem.imem_addr, 32'h0);
    adv();
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 199) != 0;
      br = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | ($urandom_range(0, 7) == 0 ? 32'h2 : 32'h0);
      hnd = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      epc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | ($urandom_range(0, 9) == 0 ? 32'h1 : 32'h0);
      sel = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      stall = $urandom_range(0, 7) == 0;
      pstall = $urandom_range(0, 7) == 0;
      imem.imem_ready = $urandom_range(0, 9) < 6;
      imem.imem_rdata = $urandom;
      #1;
      model_compare();
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
